div_issue: RTL

- EX-side controller for the M-extension divide/remainder ops (DIV/DIVU/REM/REMU). It sits directly upstream of the multi-cycle iterative divider.
- Accepts a decoded divide request from EX, latches its operands, and holds start to the divider for the whole operation while stalling the pipeline.
- When the divider signals ready, it captures the result and issues a single-cycle register write-back.
- A flush (jump/interrupt) cancels the operation cleanly.

---
 rtl/div_issue.sv | 84 ++++++++
 1 files changed

// File: rtl/div_issue.sv
// div_issue: EX-side issue/write-back controller for the iterative M-extension divider
module div_issue #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid_i,
  input  logic [2:0]    op_i,
  input  logic [DW-1:0] dividend_i,
  input  logic [DW-1:0] divisor_i,
  input  logic [AW-1:0] reg_waddr_i,
  input  logic          flush_i,
  output logic          div_start_o,
  output logic [2:0]    div_op_o,
  output logic [DW-1:0] div_dividend_o,
  output logic [DW-1:0] div_divisor_o,
  output logic [AW-1:0] div_reg_waddr_o,
  input  logic [DW-1:0] div_result_i,
  input  logic          div_ready_i,
  input  logic          div_busy_i,
  output logic          hold_o,
  output logic          reg_we_o,
  output logic [AW-1:0] reg_waddr_o,
  output logic [DW-1:0] reg_wdata_o
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state, state_nxt;
  logic accept;
  logic capture;
  logic busy_unused;
  assign busy_unused = div_busy_i;
  assign accept  = (state == IDLE) & req_valid_i & op_i[2] & ~flush_i;
  assign capture = (state == WAIT) & div_ready_i & ~flush_i;
  // state register; reset abandons any op, dropping start so the divider idles
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nxt;
  // next state plus start/stall/write-enable; start falls on ready so the divider cannot restart
  always_comb begin
    state_nxt   = state;
    div_start_o = 1'b0;
    hold_o      = 1'b0;
    reg_we_o    = 1'b0;
    case (state)
      IDLE: begin
        hold_o    = accept;
        state_nxt = accept ? WAIT : IDLE;
      end
      WAIT: begin
        hold_o      = ~flush_i;
        div_start_o = ~div_ready_i & ~flush_i;
        state_nxt   = flush_i ? IDLE : (div_ready_i ? DONE : WAIT);
      end
      DONE: begin
        reg_we_o  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
  // operands latched on accept and held steady for the divider
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      div_op_o        <= '0;
      div_dividend_o  <= '0;
      div_divisor_o   <= '0;
      div_reg_waddr_o <= '0;
    end else if (accept) begin
      div_op_o        <= op_i;
      div_dividend_o  <= dividend_i;
      div_divisor_o   <= divisor_i;
      div_reg_waddr_o <= reg_waddr_i;
    end
  // result captured on an unflushed ready; presented with the write enable in DONE
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      reg_waddr_o <= '0;
      reg_wdata_o <= '0;
    end else if (capture) begin
      reg_waddr_o <= div_reg_waddr_o;
      reg_wdata_o <= div_result_i;
    end
endmodule
